l2_sram_port_ctrl: RTL

Front-end controller for the L2 cache's 0rw1r1w OpenRAM macros (one write port, one read port). It owns both macro ports and gives the cache pipeline a valid/ready write channel, a valid/ready read channel and a registered read-response channel. It also zero-initialises every word after reset, because the macro has no reset. It resolves same-cycle read/write address collisions so the macro never sees a simultaneous same-address access.

---
 rtl/l2_sram_pkg.sv | 18 +
 rtl/l2_sram_port_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/l2_sram_pkg.sv
// Shared types and default widths for the L2 SRAM port controller.
// Provides the FSM state enum and the request bundle layout.
package l2_sram_pkg;

   localparam int L2_DATA_WIDTH = 19;
   localparam int L2_ADDR_WIDTH = 7;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   typedef struct packed {
      logic [L2_ADDR_WIDTH-1:0] addr;
      logic [L2_DATA_WIDTH-1:0] data;
   } req_t;

endpackage

// File: rtl/l2_sram_port_ctrl.sv
// Front-end for an L2 0rw1r1w SRAM macro: zero-init sweep after reset,
// valid/ready write and read channels, registered read response.
// Ports: clk, rst (async, active-high); wr_valid/wr_ready/wr_addr/wr_data;
//   rd_valid/rd_ready/rd_addr; rd_rsp_valid/rd_rsp_data; init_done;
//   sram_csb0/sram_addr0/sram_din0 (write port); sram_csb1/sram_addr1/
//   sram_dout1 (read port).
// Build option: define L2_SRAM_CTRL_BYPASS_EN to serve same-address
//   read/write collisions from a write-first bypass register instead of
//   stalling the read channel.
module l2_sram_port_ctrl
   import l2_sram_pkg::*;
#(
   parameter int DATA_WIDTH = L2_DATA_WIDTH,
   parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
   parameter int DEPTH = 1 << ADDR_WIDTH,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_rsp_valid,
   output logic [DATA_WIDTH-1:0] rd_rsp_data,
   output logic                  init_done,
   output logic                  sram_csb0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  init_done_q, init_done_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic rdy_st;
   logic addr_eq;
   logic rd_rdy;
   logic wr_fire;
   logic rd_fire;
   logic byp_hit;

   assign rdy_st  = (state_q == ST_READY);
   assign addr_eq = (rd_addr == wr_addr);
   assign wr_fire = wr_valid && rdy_st;

`ifdef L2_SRAM_CTRL_BYPASS_EN
   logic                  byp_q, byp_d;
   logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

   assign rd_rdy  = rdy_st;
   assign rd_fire = rd_valid && rd_rdy;
   assign byp_hit = wr_fire && rd_fire && addr_eq;

   always_comb begin
      byp_d      = byp_hit;
      byp_data_d = byp_data_q;
      if (byp_hit) begin
         byp_data_d = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byp_q      <= 1'b0;
         byp_data_q <= '0;
      end else begin
         byp_q      <= byp_d;
         byp_data_q <= byp_data_d;
      end
   end
`else
   // Hold the read back while a same-address write goes in; it is then
   // accepted on a later cycle and sees the new data.
   assign rd_rdy  = rdy_st && !(wr_valid && rd_valid && addr_eq);
   assign rd_fire = rd_valid && rd_rdy;
   assign byp_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         rd_pend_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         rd_pend_q   <= rd_pend_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q | rdy_st;
      rd_pend_d   = rd_fire;
      rsp_valid_d = rd_pend_q;
      rsp_data_d  = rsp_data_q;
      unique case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            cnt_d = '0;
         end
         default: state_d = ST_INIT;
      endcase
      if (rd_pend_q) begin
`ifdef L2_SRAM_CTRL_BYPASS_EN
         rsp_data_d = byp_q ? byp_data_q : sram_dout1;
`else
         rsp_data_d = sram_dout1;
`endif
      end
   end

   // Outputs
   always_comb begin
      wr_ready   = 1'b0;
      rd_ready   = 1'b0;
      sram_csb0  = 1'b1;
      sram_addr0 = wr_addr;
      sram_din0  = wr_data;
      sram_csb1  = 1'b1;
      sram_addr1 = rd_addr;
      if (!rst) begin
         if (state_q == ST_INIT) begin
            sram_csb0  = 1'b0;
            sram_addr0 = cnt_q;
            sram_din0  = INIT_VALUE;
         end else begin
            wr_ready  = 1'b1;
            rd_ready  = rd_rdy;
            sram_csb0 = !wr_fire;
            sram_csb1 = !rd_fire || byp_hit;
         end
      end
   end

   assign init_done    = init_done_q;
   assign rd_rsp_valid = rsp_valid_q;
   assign rd_rsp_data  = rsp_data_q;

endmodule
